// File: rtl/regfile_wb_queue_pkg.sv
// Shared CPU constants for the write-back path and register file.
package cpu_pkg;

    localparam int REG_AW   = 4;
    localparam int NUM_REGS = 16;
    localparam int DATA_W   = 16;

    localparam logic [REG_AW-1:0] REG_ZERO = 4'h0;
    localparam logic [REG_AW-1:0] REG_ONES = 4'hF;

    // r0 and r15 are hardwired: writes to them are dropped and reads never forward.
    function automatic logic is_hardwired(input logic [REG_AW-1:0] r);
        return (r == REG_ZERO) || (r == REG_ONES);
    endfunction

endpackage

// File: rtl/regfile_wb_queue_if.sv
// Bus bundle between the producers, the write-back queue and the register file.
interface regfile_wb_queue_if
    import cpu_pkg::*;
#(
    parameter int WIDTH = DATA_W
);
    logic              alu_valid;
    logic              alu_ready;
    logic [REG_AW-1:0] alu_rd;
    logic [WIDTH-1:0]  alu_data;
    logic              mem_valid;
    logic              mem_ready;
    logic [REG_AW-1:0] mem_rd;
    logic [WIDTH-1:0]  mem_data;
    logic              wb_hold;
    logic              we;
    logic [REG_AW-1:0] wr;
    logic [WIDTH-1:0]  wd;
    logic [REG_AW-1:0] rr1;
    logic [REG_AW-1:0] rr2;
    logic              fwd1_hit;
    logic [WIDTH-1:0]  fwd1_data;
    logic              fwd2_hit;
    logic [WIDTH-1:0]  fwd2_data;
    logic [NUM_REGS-1:0] pending;
    logic              full;
    logic              empty;

    modport slave (
        input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
               wb_hold, rr1, rr2,
        output alu_ready, mem_ready, we, wr, wd, fwd1_hit, fwd1_data,
               fwd2_hit, fwd2_data, pending, full, empty
    );

    modport master (
        output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
               wb_hold, rr1, rr2,
        input  alu_ready, mem_ready, we, wr, wd, fwd1_hit, fwd1_data,
               fwd2_hit, fwd2_data, pending, full, empty
    );
endinterface

// File: rtl/regfile_wb_queue_fwd.sv
// Age-ordered forwarding lookup: youngest valid queue entry targeting rr_i.
module wb_fwd_match
    import cpu_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int DEPTH = 4,
    parameter int PW    = 2
) (
    input  logic [REG_AW-1:0] rd_i   [DEPTH],
    input  logic [WIDTH-1:0]  data_i [DEPTH],
    input  logic [DEPTH-1:0]  valid_i,
    input  logic [PW-1:0]     head_i,
    input  logic [REG_AW-1:0] rr_i,
    output logic              hit_o,
    output logic [WIDTH-1:0]  data_o
);
    // Walk oldest to youngest from the head; later matches overwrite earlier ones.
    always_comb begin
        logic [PW-1:0] idx;
        hit_o  = 1'b0;
        data_o = '0;
        idx    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_i + PW'(k);
            if (valid_i[idx] && (rd_i[idx] == rr_i) && !is_hardwired(rr_i)) begin
                hit_o  = 1'b1;
                data_o = data_i[idx];
            end
        end
    end
endmodule

// File: rtl/regfile_wb_queue.sv
// In-order write-back FIFO feeding the register file write port, with
// pending-write mask and youngest-entry forwarding for two read ports.
module regfile_wb_queue
    import cpu_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int DEPTH = 4,
    parameter int PW    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    regfile_wb_queue_if.slave bus
);
    logic [REG_AW-1:0] rd_q   [DEPTH];
    logic [WIDTH-1:0]  data_q [DEPTH];
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW:0]       count_q, count_d;

    logic              empty, full, deq, slot_ok;
    logic              mem_fire, alu_fire, enq;
    logic [REG_AW-1:0] enq_rd;
    logic [WIDTH-1:0]  enq_data;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (PW+1)'(DEPTH));
    assign deq     = !empty && !bus.wb_hold;
    assign slot_ok = !full || deq;

    assign bus.mem_ready = slot_ok;
    assign bus.alu_ready = slot_ok && !bus.mem_valid;
    assign mem_fire      = bus.mem_valid && bus.mem_ready;
    assign alu_fire      = bus.alu_valid && bus.alu_ready;
    assign enq_rd        = mem_fire ? bus.mem_rd   : bus.alu_rd;
    assign enq_data      = mem_fire ? bus.mem_data : bus.alu_data;
    // Hardwired destinations complete the handshake but never occupy a slot.
    assign enq           = (mem_fire || alu_fire) && !is_hardwired(enq_rd);

    assign bus.we    = deq;
    assign bus.wr    = empty ? '0 : rd_q[rd_ptr_q];
    assign bus.wd    = empty ? '0 : data_q[rd_ptr_q];
    assign bus.empty = empty;
    assign bus.full  = full;

    // Next-state for pointers, occupancy and per-entry valids.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        valid_d  = valid_q;
        if (deq) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + 1'b1;
        end
        // Set after clear: when full, the enqueue reuses the slot being drained.
        if (enq) begin
            valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d          = wr_ptr_q + 1'b1;
        end
        if (enq && !deq)      count_d = count_q + 1'b1;
        else if (!enq && deq) count_d = count_q - 1'b1;
    end

    // Control state register with async reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
        end
    end

    // Entry payload storage; qualified by valid_q, so no reset needed.
    always_ff @(posedge clk) begin
        if (enq) begin
            rd_q[wr_ptr_q]   <= enq_rd;
            data_q[wr_ptr_q] <= enq_data;
        end
    end

    // Pending mask: one-hot destination of every valid entry.
    always_comb begin
        bus.pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i]) bus.pending = bus.pending | (NUM_REGS'(1) << rd_q[i]);
        end
    end

    wb_fwd_match #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PW(PW)) u_fwd1 (
        .rd_i    (rd_q),
        .data_i  (data_q),
        .valid_i (valid_q),
        .head_i  (rd_ptr_q),
        .rr_i    (bus.rr1),
        .hit_o   (bus.fwd1_hit),
        .data_o  (bus.fwd1_data)
    );

    wb_fwd_match #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PW(PW)) u_fwd2 (
        .rd_i    (rd_q),
        .data_i  (data_q),
        .valid_i (valid_q),
        .head_i  (rd_ptr_q),
        .rr_i    (bus.rr2),
        .hit_o   (bus.fwd2_hit),
        .data_o  (bus.fwd2_data)
    );
endmodule
